// File: rtl/ex_muldiv.sv
// ex_muldiv -- execute-stage RV32M unit with EX/MEM output register.
//
// Purpose:
//   Non-M instructions pass i_alu_res through. MUL/MULH/MULHSU/MULHU
//   complete in one cycle. DIV/DIVU/REM/REMU run on a radix-2 restoring
//   divider that works on operand magnitudes, with signs applied afterwards.
//   A divide accepted in cycle T holds o_busy high in cycles T+1..T+33.
//   Its result appears with o_vld=1 in cycle T+34.
//
// Configuration macro:
//   MULDIV_EARLY_OUT_EN -- when defined, divide-by-zero and signed overflow
//   bypass the divider and complete in one cycle like MUL.
//
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_vld        upstream instruction valid
//   i_flush      kill any in-flight or presented op
//   i_inst/i_pc  instruction and PC, forwarded to o_inst/o_pc
//   i_rs1_rdata  operand 1 (dividend / multiplicand)
//   i_rs2_rdata  operand 2 (divisor / multiplier)
//   i_rd_waddr   destination register index
//   i_rd_wen     destination write enable
//   i_md_en      instruction is RV32M
//   i_mdsel      funct3 of the RV32M op
//   i_alu_res    ALU result, used when i_md_en=0
//   o_busy       divider occupied; upstream stalls and holds its inputs
//   o_vld, o_res, o_rd_waddr, o_rd_wen, o_inst, o_pc -- registered EX/MEM outputs
module ex_muldiv (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_vld,
   input  logic        i_flush,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1_rdata,
   input  logic [31:0] i_rs2_rdata,
   input  logic [4:0]  i_rd_waddr,
   input  logic        i_rd_wen,
   input  logic        i_md_en,
   input  logic [2:0]  i_mdsel,
   input  logic [31:0] i_alu_res,
   output logic        o_busy,
   output logic        o_vld,
   output logic [31:0] o_res,
   output logic [4:0]  o_rd_waddr,
   output logic        o_rd_wen,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e      state_q;
   logic [5:0]  cnt_q;

   // Divider datapath: quo_q starts as |dividend| and shifts quotient bits in
   // from the right as the dividend bits shift out into rem_q.
   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] dvsr_q;
   logic [31:0] dvnd_q;     // raw dividend, returned as remainder on divide-by-zero
   logic        is_rem_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic        div0_q;

   // Pass-through fields held while the divide is in flight
   logic [31:0] inst_q;
   logic [31:0] pc_q;
   logic [4:0]  waddr_q;
   logic        wen_q;

   // Output register
   logic        vld_q;
   logic [31:0] res_q;
   logic [4:0]  rd_waddr_q;
   logic        rd_wen_q;
   logic [31:0] out_inst_q;
   logic [31:0] out_pc_q;

   // ------------------------------------------------------------------
   // Operand decode
   // ------------------------------------------------------------------
   logic        is_div_d;
   logic        div_signed_d;
   logic        rs1_neg_d;
   logic        rs2_neg_d;
   logic [31:0] rs1_abs_d;
   logic [31:0] rs2_abs_d;
   logic        div0_d;
   logic        div_long_d;

   assign is_div_d     = i_md_en & i_mdsel[2];
   assign div_signed_d = ~i_mdsel[0];                 // DIV=4, REM=6 are signed
   assign rs1_neg_d    = div_signed_d & i_rs1_rdata[31];
   assign rs2_neg_d    = div_signed_d & i_rs2_rdata[31];
   assign rs1_abs_d    = rs1_neg_d ? (32'd0 - i_rs1_rdata) : i_rs1_rdata;
   assign rs2_abs_d    = rs2_neg_d ? (32'd0 - i_rs2_rdata) : i_rs2_rdata;
   assign div0_d       = (i_rs2_rdata == 32'd0);

`ifdef MULDIV_EARLY_OUT_EN
   logic        ovf_d;
   logic [31:0] early_res_d;
   assign ovf_d       = div_signed_d & (i_rs1_rdata == 32'h8000_0000) &
                        (i_rs2_rdata == 32'hFFFF_FFFF);
   assign early_res_d = div0_d ? (i_mdsel[1] ? i_rs1_rdata : 32'hFFFF_FFFF)
                               : (i_mdsel[1] ? 32'd0 : 32'h8000_0000);
   assign div_long_d  = is_div_d & ~(div0_d | ovf_d);
`else
   assign div_long_d  = is_div_d;
`endif

   // ------------------------------------------------------------------
   // Single-cycle multiplier: both operands are extended to 64 bits
   // according to their signedness, so the low 64 product bits are exact.
   // ------------------------------------------------------------------
   logic        mul_a_signed_d;
   logic        mul_b_signed_d;
   logic [63:0] mul_a_d;
   logic [63:0] mul_b_d;
   logic [63:0] prod_d;
   logic [31:0] mul_res_d;

   assign mul_a_signed_d = (i_mdsel[1:0] != 2'd3);    // MULH, MULHSU
   assign mul_b_signed_d = (i_mdsel[1:0] == 2'd1);    // MULH only
   assign mul_a_d   = {{32{mul_a_signed_d & i_rs1_rdata[31]}}, i_rs1_rdata};
   assign mul_b_d   = {{32{mul_b_signed_d & i_rs2_rdata[31]}}, i_rs2_rdata};
   assign prod_d    = mul_a_d * mul_b_d;
   assign mul_res_d = (i_mdsel[1:0] == 2'd0) ? prod_d[31:0] : prod_d[63:32];

   // Result loaded on a single-cycle accept
   logic [31:0] acc_res_d;
   always_comb begin
      acc_res_d = i_alu_res;
      if (i_md_en) begin
         acc_res_d = mul_res_d;
`ifdef MULDIV_EARLY_OUT_EN
         if (i_mdsel[2]) begin
            acc_res_d = early_res_d;
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // Restoring divider step and final sign fix-up
   // ------------------------------------------------------------------
   logic [32:0] shift_d;
   logic [32:0] trial_d;
   logic [31:0] quo_fix_d;
   logic [31:0] rem_fix_d;
   logic [31:0] div_res_d;

   assign shift_d   = {rem_q, quo_q[31]};
   // Remainder stays below the divisor, so bit 32 is a clean borrow flag
   assign trial_d   = shift_d - {1'b0, dvsr_q};
   assign quo_fix_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
   assign rem_fix_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
   // Signed overflow needs no special case: |q| = 0x80000000 negates to
   // itself and the remainder is already 0.
   assign div_res_d = div0_q ? (is_rem_q ? dvnd_q : 32'hFFFF_FFFF)
                             : (is_rem_q ? rem_fix_d : quo_fix_d);

   assign o_busy = (state_q != S_IDLE);

   // ------------------------------------------------------------------
   // FSM, divider registers and EX/MEM output register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 6'd0;
         quo_q      <= 32'd0;
         rem_q      <= 32'd0;
         dvsr_q     <= 32'd0;
         dvnd_q     <= 32'd0;
         is_rem_q   <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         inst_q     <= 32'd0;
         pc_q       <= 32'd0;
         waddr_q    <= 5'd0;
         wen_q      <= 1'b0;
         vld_q      <= 1'b0;
         res_q      <= 32'd0;
         rd_waddr_q <= 5'd0;
         rd_wen_q   <= 1'b0;
         out_inst_q <= 32'd0;
         out_pc_q   <= 32'd0;
      end else if (i_flush) begin
         // Flush beats both a simultaneous accept and the DONE load
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         vld_q    <= 1'b0;
         rd_wen_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Here o_busy=0 and i_flush=0, so i_vld alone means accept
               if (i_vld && div_long_d) begin
                  state_q   <= S_DIV;
                  cnt_q     <= 6'd31;
                  quo_q     <= rs1_abs_d;
                  rem_q     <= 32'd0;
                  dvsr_q    <= rs2_abs_d;
                  dvnd_q    <= i_rs1_rdata;
                  is_rem_q  <= i_mdsel[1];
                  neg_quo_q <= rs1_neg_d ^ rs2_neg_d;
                  neg_rem_q <= rs1_neg_d;
                  div0_q    <= div0_d;
                  inst_q    <= i_inst;
                  pc_q      <= i_pc;
                  waddr_q   <= i_rd_waddr;
                  wen_q     <= i_rd_wen;
                  vld_q     <= 1'b0;
                  rd_wen_q  <= 1'b0;
               end else if (i_vld) begin
                  vld_q      <= 1'b1;
                  res_q      <= acc_res_d;
                  rd_waddr_q <= i_rd_waddr;
                  rd_wen_q   <= i_rd_wen;
                  out_inst_q <= i_inst;
                  out_pc_q   <= i_pc;
               end else begin
                  vld_q    <= 1'b0;
                  rd_wen_q <= 1'b0;
               end
            end
            S_DIV: begin
               vld_q    <= 1'b0;
               rd_wen_q <= 1'b0;
               if (!trial_d[32]) begin
                  rem_q <= trial_d[31:0];
               end else begin
                  rem_q <= shift_d[31:0];
               end
               quo_q <= {quo_q[30:0], ~trial_d[32]};
               if (cnt_q == 6'd0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            S_DONE: begin
               state_q    <= S_IDLE;
               vld_q      <= 1'b1;
               res_q      <= div_res_d;
               rd_waddr_q <= waddr_q;
               rd_wen_q   <= wen_q;
               out_inst_q <= inst_q;
               out_pc_q   <= pc_q;
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 6'd0;
            end
         endcase
      end
   end

   assign o_vld      = vld_q;
   assign o_res      = res_q;
   assign o_rd_waddr = rd_waddr_q;
   assign o_rd_wen   = rd_wen_q;
   assign o_inst     = out_inst_q;
   assign o_pc       = out_pc_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports i_clk, input, 1, the single clock; i_rst_n, input, 1, synchronous active-low reset.
REQ-002 SHALL have ports i_vld (input, 1, upstream instruction valid) and i_flush (input, 1, kill in-flight op).
REQ-003 SHALL have ports i_inst and i_pc, both input, 32, instruction and PC, passed through to the EX/MEM register.
REQ-004 SHALL have ports i_rs1_rdata and i_rs2_rdata, both input, 32, operands.
REQ-005 SHALL have ports i_rd_waddr (input, 5) and i_rd_wen (input, 1), destination register.
REQ-006 SHALL have ports i_md_en (input, 1, instruction is RV32M) and i_mdsel (input, 3, funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 SHALL have port i_alu_res, input, 32, ALU result used when i_md_en=0.
REQ-008 SHALL have port o_busy, output, 1, upstream must stall and hold all inputs.
REQ-009 SHALL have registered outputs o_vld (1), o_res (32), o_rd_waddr (5), o_rd_wen (1), o_inst (32) and o_pc (32).

Function
REQ-010 SHALL accept an instruction on a rising edge where i_vld=1, o_busy=0 and i_flush=0.
REQ-011 Non-M or MUL* accept in cycle T SHALL present the result on the outputs with o_vld=1 in cycle T+1.
REQ-012 MUL SHALL return the low 32 bits of the product; MULH/MULHSU/MULHU SHALL return the high 32 bits of the 64-bit product of s*s, s*u and u*u operands.
REQ-013 DIV*/REM* SHALL use a radix-2 restoring divider on operand magnitudes, with signs applied to the result.
REQ-014 Divider FSM states: IDLE (on accept of a divide) -> DIV (32 iterations, 6-bit counter 31..0) -> DONE (sign fix, load output register) -> IDLE.
REQ-015 A divide accepted in cycle T SHALL give o_busy=1 in cycles T+1..T+33, o_vld=1 with the result in cycle T+34, and o_busy=0 in cycle T+34.
REQ-016 o_vld SHALL be 0 during DIV and DONE; there is no downstream backpressure.
REQ-017 Signed quotient SHALL be negative iff operand signs differ; remainder sign SHALL follow the dividend.
REQ-018 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU).
REQ-019 Signed overflow, 0x80000000 / 0xFFFFFFFF, SHALL return quotient 0x80000000 and remainder 0.
REQ-020 i_flush=1 SHALL return the FSM to IDLE, drop any in-flight or presented op, and force o_vld=0 and o_busy=0 in the next cycle.
REQ-021 i_flush SHALL take priority over a simultaneous accept and over the DONE update.
REQ-022 i_vld=0 with o_busy=0 SHALL load a bubble: o_vld=0, o_rd_wen=0.
REQ-023 o_rd_wen SHALL equal the latched i_rd_wen qualified by o_vld.

Reset
REQ-024 i_rst_n=0 at a rising edge SHALL force state IDLE, counter 0, and o_busy, o_vld and o_rd_wen to 0.
REQ-025 The same reset SHALL force o_rd_waddr to 0 and o_res, o_inst and o_pc to 0x00000000.
REQ-026 Reset asserted mid-divide SHALL abandon the op with no result produced; the first accept after reset SHALL behave as in REQ-010.

Configuration
REQ-027 With macro MULDIV_EARLY_OUT_EN defined, divide-by-zero and signed-overflow cases SHALL bypass DIV/DONE and complete like MUL (REQ-011), with o_busy never asserted.
REQ-028 Without MULDIV_EARLY_OUT_EN, those cases SHALL take the full REQ-015 latency and still produce the REQ-018/REQ-019 values.

Verification
REQ-029 MUL 0x00010000*0x00010000, then MULHU 0xFFFFFFFF*0xFFFFFFFF -> o_res 0x00000000 at T+1, then 0xFFFFFFFE at T+2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 at T -> busy T+1..T+33, o_res 0xFFFFFFFD at T+34; REM of the same operands -> 0xFFFFFFFF.
REQ-031 DIVU 100/0 -> 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF -> 0, at T+34 without the macro and at T+1 with it.
REQ-032 i_flush pulsed at T+10 of a divide -> o_busy=0 at T+11, no o_vld, and a following ADD result appears one cycle after its accept.
REQ-033 i_rst_n low at T+5 of a divide -> all outputs at reset values next cycle; a new MUL 3*5 then gives 15 one cycle after its accept.
